fifo_fwft_adapter: RTL and testbench

- Read-side adapter placed directly downstream of the team's synchronous FIFO. That FIFO has registered read data with 1-cycle latency and separate chip-select/enable.
- Converts the FIFO into a first-word-fall-through valid/ready stream for the next datapath stage.
- Tracks in-flight reads and keeps a 2-entry output buffer, so the stream sustains 1 word/cycle under backpressure without overrunning or losing words.

---
 rtl/fifo_fwft_adapter.sv | 101 ++++++++++
 tb/tb_fifo_fwft_adapter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_adapter.sv
// Read-side adapter for the synchronous FIFO (registered read data, 1-cycle
// latency). It turns the FIFO into a first-word-fall-through valid/ready stream.
// A 2-entry head/tail buffer plus an in-flight flag lets the stream keep 1 word
// per cycle under backpressure without overrunning the buffer.
module fifo_fwft_adapter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_cs,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [1:0]            level
);

   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic [1:0]            level_q, level_d;
   logic                  in_flight_q;
   logic                  discard_q;
   logic                  pop;
   logic                  capture;
   logic                  rd_en;
   logic [2:0]            occ;

   // Read issue: words held plus the word in flight, less the word leaving now,
   // must stay below 2. This keeps total occupancy at 2 or fewer. The rst_n
   // term keeps the FIFO quiet while reset is asserted.
   always_comb begin
      pop     = (level_q != 2'd0) & m_ready;
      occ     = {1'b0, level_q} + {2'b00, in_flight_q} - {2'b00, pop};
      rd_en   = rst_n & ~fifo_empty & ~flush & (occ < 3'd2);
      capture = in_flight_q & ~discard_q & ~flush;
   end

   // Buffer update: capture goes to head when the buffer is (or is becoming)
   // empty. Otherwise it goes to tail. A pop at level 2 shifts tail into head.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      level_d = level_q;
      case (level_q)
         2'd0: begin
            if (capture) begin
               head_d  = fifo_data;
               level_d = 2'd1;
            end
         end
         2'd1: begin
            if (capture && pop) begin
               head_d = fifo_data;
            end else if (capture) begin
               tail_d  = fifo_data;
               level_d = 2'd2;
            end else if (pop) begin
               level_d = 2'd0;
            end
         end
         2'd2: begin
            if (pop) begin
               head_d  = tail_q;
               level_d = 2'd1;
            end
         end
         default: level_d = 2'd0;
      endcase
      if (flush) begin
         level_d = 2'd0;
      end
   end

   // State registers. Data registers keep their contents across a flush, so
   // m_data retains the last value once the buffer is empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q      <= '0;
         tail_q      <= '0;
         level_q     <= 2'd0;
         in_flight_q <= 1'b0;
         discard_q   <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         level_q     <= level_d;
         in_flight_q <= rd_en;
         discard_q   <= flush & in_flight_q;
      end
   end

   assign fifo_rd_en = rd_en;
   assign fifo_rd_cs = rd_en;
   assign m_valid    = (level_q != 2'd0);
   assign m_data     = head_q;
   assign level      = level_q;

endmodule

// File: tb/tb_fifo_fwft_adapter.sv
// Bench for fifo_fwft_adapter: behavioural FIFO model with 1-cycle read latency,
// an expected-word queue filled at stimulus time, and a negedge monitor that
// pops and compares every accepted word.
module tb_fifo_fwft_adapter;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       fifo_empty;
   logic       fifo_rd_cs;
   logic       fifo_rd_en;
   logic [7:0] fifo_data;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic [1:0] level;

   fifo_fwft_adapter #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .fifo_empty (fifo_empty),
      .fifo_rd_cs (fifo_rd_cs),
      .fifo_rd_en (fifo_rd_en),
      .fifo_data  (fifo_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .level      (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0]  mem [0:1023];
   int unsigned wr_ptr = 0;
   int unsigned rd_ptr = 0;
   logic [7:0]  exp_q [$];

   int cyc          = 0;
   int rd_cnt       = 0;
   int pop_cnt      = 0;
   int first_rd_cyc = 0;
   int first_pop_cyc = 0;
   int last_pop_cyc = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   assign fifo_empty = (rd_ptr == wr_ptr);

   // FIFO model: registered read data, one word per rd_en.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) begin
         fifo_data <= mem[rd_ptr[9:0]];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_word(input logic [7:0] v, input bit expect_out);
      mem[wr_ptr[9:0]] = v;
      wr_ptr++;
      if (expect_out) exp_q.push_back(v);
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Monitor: scoreboard compare on every accepted word, stall stability,
   // level bound, and read-strobe bookkeeping.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("rd_cs_eq_rd_en", int'(fifo_rd_cs), int'(fifo_rd_en));
         chk("level_le_2", int'(level <= 2'd2), 1);
         if (prev_stall) begin
            chk("stall_valid", int'(m_valid), 1);
            chk("stall_data", int'(m_data), int'(prev_data));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_word: got %0h expected none", m_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               chk("data_order", int'(m_data), int'(e));
            end
            if (pop_cnt == 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            pop_cnt++;
         end
         if (fifo_rd_en) begin
            if (rd_cnt == 0) first_rd_cyc = cyc;
            rd_cnt++;
         end
         prev_stall = m_valid && !m_ready && !flush;
         prev_data  = m_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      int n;
      rst_n   = 1'b0;
      flush   = 1'b0;
      m_ready = 1'b1;

      // Reset with a non-empty FIFO, then stream 0x01..0x10.
      for (int i = 1; i <= 16; i++) push_word(8'(i), 1'b1);
      repeat (3) @(posedge clk);
      #1; #3;
      chk("rst_rd_en", int'(fifo_rd_en), 0);
      chk("rst_rd_cs", int'(fifo_rd_cs), 0);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_data", int'(m_data), 0);
      chk("rst_level", int'(level), 0);
      rd_cnt  = 0;
      pop_cnt = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #3;
      chk("rst_release_rd_en", int'(fifo_rd_en), 1);
      drain("stream_drain", 100);
      chk("stream_pops", pop_cnt, 16);
      chk("stream_gapfree", last_pop_cyc - first_pop_cyc, 15);
      chk("stream_latency", first_pop_cyc - first_rd_cyc, 2);
      @(posedge clk); #4;
      chk("stream_end_valid", int'(m_valid), 0);
      chk("stream_end_level", int'(level), 0);

      // Backpressure: only two reads issue while stalled.
      @(posedge clk); #1;
      m_ready = 1'b0;
      rd_cnt  = 0;
      pop_cnt = 0;
      for (int i = 0; i < 6; i++) push_word(8'hA0 + 8'(i), 1'b1);
      repeat (6) @(posedge clk);
      #4;
      chk("bp_rd_count", rd_cnt, 2);
      chk("bp_level", int'(level), 2);
      chk("bp_m_valid", int'(m_valid), 1);
      chk("bp_m_data", int'(m_data), 8'hA0);
      m_ready = 1'b1;
      drain("bp_drain", 50);
      chk("bp_pops", pop_cnt, 6);
      chk("bp_gapfree", last_pop_cyc - first_pop_cyc, 5);

      // Random stall over 256 words.
      @(posedge clk); #1;
      pop_cnt = 0;
      for (int i = 0; i < 256; i++) push_word(8'(i * 7 + 3), 1'b1);
      n = 0;
      while (exp_q.size() != 0 && n < 4000) begin
         @(posedge clk); #1;
         m_ready = 1'($urandom_range(0, 1));
         n++;
      end
      drain("rand_drain", 20);
      chk("rand_pops", pop_cnt, 256);

      // Flush while a read is in flight: 0x11 and 0x22 are lost, 0x33 follows.
      m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      push_word(8'h11, 1'b0);
      n = 0;
      while (level != 2'd1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("flush_setup_level", int'(level), 1);
      push_word(8'h22, 1'b0);
      push_word(8'h33, 1'b1);
      #3;
      chk("flush_rd_issue", int'(fifo_rd_en), 1);
      @(posedge clk); #1;
      flush = 1'b1;
      #3;
      chk("flush_rd_low", int'(fifo_rd_en), 0);
      @(posedge clk); #1;
      flush = 1'b0;
      #3;
      chk("flush_m_valid", int'(m_valid), 0);
      chk("flush_level", int'(level), 0);
      pop_cnt = 0;
      m_ready = 1'b1;
      drain("flush_drain", 20);
      repeat (3) @(posedge clk);
      #4;
      chk("flush_pops", pop_cnt, 1);
      chk("flush_end_level", int'(level), 0);

      // Last word: a single 0x5A.
      @(posedge clk); #1;
      rd_cnt  = 0;
      pop_cnt = 0;
      push_word(8'h5A, 1'b1);
      #3;
      chk("last_rd_en", int'(fifo_rd_en), 1);
      @(posedge clk); #4;
      chk("last_fifo_empty", int'(fifo_empty), 1);
      chk("last_rd_low", int'(fifo_rd_en), 0);
      repeat (5) @(posedge clk);
      #4;
      chk("last_rd_count", rd_cnt, 1);
      chk("last_pops", pop_cnt, 1);
      chk("last_m_valid", int'(m_valid), 0);
      chk("last_level", int'(level), 0);
      chk("last_exp_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
